// File: rtl/pads_cfg_sequencer.sv
// Hardware sequencer that walks the pad configuration window and writes each
// pad's output-enable bit from a latched profile, optionally reading each
// register back to confirm it took.
//
// state  | meaning
// IDLE   | waiting for start
// WR_REQ | write of profile[idx] to BASE_ADDR+idx on the bus, waiting for ack
// WR_GAP | bus idle cycle after a write; stale slave ack ignored
// RD_REQ | readback of BASE_ADDR+idx on the bus, waiting for ack
// RD_GAP | bus idle cycle after a read; stale slave ack ignored
// DONE   | one-cycle completion pulse
// ERR    | pass stopped by timeout, readback mismatch or abort; err held
module pads_cfg_sequencer #(
   parameter logic [31:0] BASE_ADDR = 32'h3000_6000,
   parameter int          NUM_PADS  = 38,
   parameter int          TIMEOUT   = 16
) (
   input  logic                wb_clk_i,
   input  logic                wb_rst_i,
   input  logic                start,
   input  logic                abort,
   input  logic                verify_en,
   input  logic [NUM_PADS-1:0] profile_oen,
   output logic                busy,
   output logic                done,
   output logic                err,
   output logic [1:0]          err_code,
   output logic [5:0]          err_idx,
   output logic                wbm_cyc_o,
   output logic                wbm_stb_o,
   output logic                wbm_we_o,
   output logic [3:0]          wbm_sel_o,
   output logic [31:0]         wbm_adr_o,
   output logic [31:0]         wbm_dat_o,
   input  logic [31:0]         wbm_dat_i,
   input  logic                wbm_ack_i
);

   localparam int          CNT_W    = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [5:0]  IDX_LAST = 6'(NUM_PADS - 1);

   localparam logic [1:0]  CODE_NONE    = 2'b00;
   localparam logic [1:0]  CODE_TIMEOUT = 2'b01;
   localparam logic [1:0]  CODE_MISMAT  = 2'b10;
   localparam logic [1:0]  CODE_ABORT   = 2'b11;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      WR_REQ = 3'd1,
      WR_GAP = 3'd2,
      RD_REQ = 3'd3,
      RD_GAP = 3'd4,
      DONE   = 3'd5,
      ERR    = 3'd6
   } state_t;

   state_t                state_q, state_d;
   logic [5:0]            idx_q, idx_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [NUM_PADS-1:0]   profile_q, profile_d;
   logic                  verify_q, verify_d;
   logic [1:0]            err_code_q, err_code_d;
   logic [5:0]            err_idx_q, err_idx_d;

   logic [63:0]           prof_ext;
   logic                  cur_bit;
   logic                  unused_dat_hi;

   // Only bit 0 of the pad register carries the OEN value.
   assign unused_dat_hi = ^wbm_dat_i[31:1];
   assign prof_ext      = 64'(profile_q);
   assign cur_bit       = prof_ext[idx_q];

   // State and datapath registers, synchronous reset.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         cnt_q      <= '0;
         profile_q  <= '0;
         verify_q   <= 1'b0;
         err_code_q <= CODE_NONE;
         err_idx_q  <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         cnt_q      <= cnt_d;
         profile_q  <= profile_d;
         verify_q   <= verify_d;
         err_code_q <= err_code_d;
         err_idx_q  <= err_idx_d;
      end
   end

   // Next-state logic and Moore bus outputs.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      cnt_d      = cnt_q;
      profile_d  = profile_q;
      verify_d   = verify_q;
      err_code_d = err_code_q;
      err_idx_d  = err_idx_q;
      wbm_cyc_o  = 1'b0;
      wbm_stb_o  = 1'b0;
      wbm_we_o   = 1'b0;
      wbm_sel_o  = 4'h0;
      wbm_adr_o  = 32'h0;
      wbm_dat_o  = 32'h0;
      busy       = 1'b0;
      done       = 1'b0;
      err        = 1'b0;

      case (state_q)
         IDLE, ERR: begin
            err = (state_q == ERR);
            if (start) begin
               profile_d  = profile_oen;
               verify_d   = verify_en;
               err_code_d = CODE_NONE;
               err_idx_d  = '0;
               idx_d      = '0;
               cnt_d      = '0;
               state_d    = WR_REQ;
            end
         end

         WR_REQ, RD_REQ: begin
            busy      = 1'b1;
            wbm_cyc_o = 1'b1;
            wbm_stb_o = 1'b1;
            wbm_we_o  = (state_q == WR_REQ);
            wbm_sel_o = 4'hF;
            wbm_adr_o = BASE_ADDR + {26'd0, idx_q};
            wbm_dat_o = (state_q == WR_REQ) ? {31'd0, cur_bit} : 32'h0;
            // Abort outranks a same-cycle ack and the timeout.
            if (abort) begin
               err_code_d = CODE_ABORT;
               err_idx_d  = idx_q;
               state_d    = ERR;
            end else if (wbm_ack_i) begin
               if (state_q == WR_REQ) begin
                  state_d = WR_GAP;
               end else if (wbm_dat_i[0] != cur_bit) begin
                  err_code_d = CODE_MISMAT;
                  err_idx_d  = idx_q;
                  state_d    = ERR;
               end else begin
                  state_d = RD_GAP;
               end
            end else if (cnt_q == CNT_LAST) begin
               err_code_d = CODE_TIMEOUT;
               err_idx_d  = idx_q;
               state_d    = ERR;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         WR_GAP, RD_GAP: begin
            busy = 1'b1;
            if (abort) begin
               err_code_d = CODE_ABORT;
               err_idx_d  = idx_q;
               state_d    = ERR;
            end else if ((state_q == WR_GAP) && verify_q) begin
               cnt_d   = '0;
               state_d = RD_REQ;
            end else if (idx_q == IDX_LAST) begin
               state_d = DONE;
            end else begin
               idx_d   = idx_q + 1'b1;
               cnt_d   = '0;
               state_d = WR_REQ;
            end
         end

         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign err_code = err_code_q;
   assign err_idx  = err_idx_q;

endmodule

// File: tb/tb_pads_cfg_sequencer.sv
// Self-checking bench for pads_cfg_sequencer: a 1-cycle-ack register slave
// with fault hooks, a transaction log, and an expected-transaction model.
module tb_pads_cfg_sequencer;
   localparam int          N    = 38;
   localparam int          TO   = 16;
   localparam logic [31:0] BASE = 32'h3000_6000;

   logic          wb_clk_i = 1'b0;
   logic          wb_rst_i = 1'b1;
   logic          start = 1'b0, abort = 1'b0, verify_en = 1'b0;
   logic [N-1:0]  profile_oen = '0;
   logic          busy, done, err;
   logic [1:0]    err_code;
   logic [5:0]    err_idx;
   logic          wbm_cyc_o, wbm_stb_o, wbm_we_o;
   logic [3:0]    wbm_sel_o;
   logic [31:0]   wbm_adr_o, wbm_dat_o, wbm_dat_i;
   logic          wbm_ack_i;

   pads_cfg_sequencer #(.BASE_ADDR(BASE), .NUM_PADS(N), .TIMEOUT(TO)) dut (
      .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .start(start), .abort(abort),
      .verify_en(verify_en), .profile_oen(profile_oen), .busy(busy), .done(done),
      .err(err), .err_code(err_code), .err_idx(err_idx),
      .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
      .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
      .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i));

   always #5 wb_clk_i = ~wb_clk_i;

   int checks = 0;
   int errors = 0;

   // Slave: registered ack one cycle after stb (so one stale ack after stb drops).
   logic        ack_q;
   logic        mem [64];
   logic        hold_en = 1'b0, force_en = 1'b0;
   logic [31:0] hold_adr = '0, force_adr = '0;
   logic [64:0] log_q[$];
   logic [64:0] exp_q[$];

   always @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         ack_q <= 1'b0;
         for (int i = 0; i < 64; i++) mem[i] <= 1'b0;
      end else begin
         ack_q <= wbm_cyc_o && wbm_stb_o && !(hold_en && wbm_adr_o == hold_adr);
         if (wbm_cyc_o && wbm_stb_o && ack_q) begin
            if (wbm_we_o) mem[wbm_adr_o[5:0]] <= wbm_dat_o[0];
            log_q.push_back({wbm_we_o, wbm_adr_o, wbm_dat_o});
         end
      end
   end

   assign wbm_ack_i = ack_q;
   assign wbm_dat_i = {31'h2AAA_5555,
                       (force_en && wbm_adr_o == force_adr) ? 1'b1 : mem[wbm_adr_o[5:0]]};

   // Abort injection: fire in the cycle where the write to abort_adr is acked.
   logic        abort_arm = 1'b0;
   logic [31:0] abort_adr = '0;
   logic [31:0] watch_adr = '0;
   logic [N-1:0] alt_profile = '0;

   // Expected bus transactions from the pass rules: write each pad, optionally
   // read it back; stop at a withheld ack, an abort, or a readback that differs.
   function automatic void build_exp(input logic [N-1:0] p, input bit v,
                                     input int force_pad, input int hold_pad,
                                     input int abort_pad);
      logic rd;
      exp_q.delete();
      for (int i = 0; i < N; i++) begin
         if (i == hold_pad) return;
         exp_q.push_back({1'b1, BASE + 32'(i), 31'd0, p[i]});
         if (i == abort_pad) return;
         if (v) begin
            rd = (i == force_pad) ? 1'b1 : p[i];
            exp_q.push_back({1'b0, BASE + 32'(i), 32'd0});
            if (rd != p[i]) return;
         end
      end
   endfunction

   function automatic logic [N-1:0] rand_profile();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      return r[N-1:0];
   endfunction

   task automatic do_start(input logic [N-1:0] p, input bit v, input bit with_abort);
      @(negedge wb_clk_i);
      log_q.delete();
      profile_oen = p;
      verify_en   = v;
      start       = 1'b1;
      abort       = with_abort;
      @(posedge wb_clk_i);
      #1;
      start = 1'b0;
      abort = 1'b0;
   endtask

   // Cycle 1 is the cycle after the edge that sampled start.
   task automatic wait_end(input int pulse_at, output int done_cyc,
                           output int end_cyc, output int watch_n);
      done_cyc = -1;
      end_cyc  = -1;
      watch_n  = 0;
      for (int c = 1; c <= 3000; c++) begin
         @(negedge wb_clk_i);
         start = 1'b0;
         abort = 1'b0;
         if (c == pulse_at) begin
            start       = 1'b1;
            profile_oen = alt_profile;
            verify_en   = ~verify_en;
         end
         if (abort_arm && wbm_cyc_o && wbm_stb_o && wbm_we_o && wbm_ack_i &&
             wbm_adr_o == abort_adr) begin
            abort     = 1'b1;
            abort_arm = 1'b0;
         end
         if (wbm_cyc_o && wbm_adr_o == watch_adr) watch_n++;
         if (done) done_cyc = c;
         if (!busy) begin
            end_cyc = c;
            break;
         end
      end
   endtask

   task automatic test_reset();
      wb_rst_i = 1'b1;
      repeat (3) @(posedge wb_clk_i);
      @(negedge wb_clk_i);
      checks++;
      if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
           busy, done, err, err_code, err_idx} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got cyc=%b adr=%h busy=%b err=%b code=%b want all 0",
                  wbm_cyc_o, wbm_adr_o, busy, err, err_code);
      end
      wb_rst_i = 1'b0;
      @(negedge wb_clk_i);
      abort = 1'b1;
      @(negedge wb_clk_i);
      abort = 1'b0;
      @(negedge wb_clk_i);
      checks++;
      if ({busy, err, err_code, wbm_cyc_o} !== 5'b0) begin
         errors++;
         $display("FAIL idle_abort got busy=%b err=%b code=%b cyc=%b want 0",
                  busy, err, err_code, wbm_cyc_o);
      end
   endtask

   task automatic test_pass(input string name, input logic [N-1:0] p, input bit v,
                            input bit with_abort);
      int dc, ec, wn;
      do_start(p, v, with_abort);
      build_exp(p, v, -1, -1, -1);
      wait_end(0, dc, ec, wn);
      checks++;
      if (dc != 3 * N * (v ? 2 : 1) + 1) begin
         errors++;
         $display("FAIL %s done_cycle got %0d want %0d", name, dc, 3 * N * (v ? 2 : 1) + 1);
      end
      checks++;
      if (err !== 1'b0 || err_code !== 2'b00) begin
         errors++;
         $display("FAIL %s err got %b code %b want 0 00", name, err, err_code);
      end
      checks++;
      if (log_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL %s txn_count got %0d want %0d", name, log_q.size(), exp_q.size());
      end
      for (int i = 0; i < log_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (log_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL %s txn[%0d] got %h want %h", name, i, log_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_mismatch();
      logic [N-1:0] p;
      int dc, ec, wn;
      p = 38'h3F_C03F_FF80;
      force_en  = 1'b1;
      force_adr = BASE + 32'd22;
      do_start(p, 1'b1, 1'b0);
      build_exp(p, 1'b1, 22, -1, -1);
      wait_end(0, dc, ec, wn);
      repeat (4) @(negedge wb_clk_i);
      force_en = 1'b0;
      checks++;
      if (err !== 1'b1 || err_code !== 2'b10 || err_idx !== 6'd22 || dc != -1) begin
         errors++;
         $display("FAIL mismatch_err got err=%b code=%b idx=%0d done_cyc=%0d want 1 10 22 -1",
                  err, err_code, err_idx, dc);
      end
      checks++;
      if (ec != 6 * 22 + 6) begin
         errors++;
         $display("FAIL mismatch_end_cycle got %0d want %0d", ec, 6 * 22 + 6);
      end
      checks++;
      if (log_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL mismatch_txn_count got %0d want %0d", log_q.size(), exp_q.size());
      end
      for (int i = 0; i < log_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (log_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL mismatch_txn[%0d] got %h want %h", i, log_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_timeout(input bit v);
      logic [N-1:0] p;
      int dc, ec, wn;
      p = rand_profile();
      hold_en   = 1'b1;
      hold_adr  = BASE + 32'd5;
      watch_adr = BASE + 32'd5;
      do_start(p, v, 1'b0);
      build_exp(p, v, -1, 5, -1);
      wait_end(0, dc, ec, wn);
      hold_en = 1'b0;
      checks++;
      if (wn != TO) begin
         errors++;
         $display("FAIL timeout_cyc_len got %0d want %0d", wn, TO);
      end
      checks++;
      if (ec != 3 * 5 * (v ? 2 : 1) + TO + 1) begin
         errors++;
         $display("FAIL timeout_end_cycle got %0d want %0d", ec, 3 * 5 * (v ? 2 : 1) + TO + 1);
      end
      checks++;
      if (err !== 1'b1 || err_code !== 2'b01 || err_idx !== 6'd5 || busy !== 1'b0 ||
          wbm_cyc_o !== 1'b0) begin
         errors++;
         $display("FAIL timeout_err got err=%b code=%b idx=%0d busy=%b cyc=%b want 1 01 5 0 0",
                  err, err_code, err_idx, busy, wbm_cyc_o);
      end
      checks++;
      if (log_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL timeout_txn_count got %0d want %0d", log_q.size(), exp_q.size());
      end
   endtask

   task automatic test_abort();
      logic [N-1:0] p;
      int dc, ec, wn;
      p = rand_profile();
      abort_arm = 1'b1;
      abort_adr = BASE + 32'd10;
      do_start(p, 1'b0, 1'b0);
      build_exp(p, 1'b0, -1, -1, 10);
      wait_end(0, dc, ec, wn);
      abort_arm = 1'b0;
      checks++;
      if (err !== 1'b1 || err_code !== 2'b11 || err_idx !== 6'd10 || ec != 3 * 10 + 3) begin
         errors++;
         $display("FAIL abort_err got err=%b code=%b idx=%0d end=%0d want 1 11 10 %0d",
                  err, err_code, err_idx, ec, 3 * 10 + 3);
      end
      checks++;
      if (log_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL abort_txn_count got %0d want %0d", log_q.size(), exp_q.size());
      end
      repeat (3) @(negedge wb_clk_i);
      checks++;
      if (err !== 1'b1 || wbm_cyc_o !== 1'b0) begin
         errors++;
         $display("FAIL abort_sticky got err=%b cyc=%b want 1 0", err, wbm_cyc_o);
      end
      test_pass("abort_restart", rand_profile(), 1'b1, 1'b0);
   endtask

   task automatic test_reset_midpass();
      logic [N-1:0] p;
      bit found;
      p = rand_profile();
      found = 1'b0;
      do_start(p, 1'b1, 1'b0);
      for (int c = 0; c < 200; c++) begin
         @(negedge wb_clk_i);
         if (wbm_cyc_o && !wbm_we_o && wbm_adr_o == BASE + 32'd3) begin
            found = 1'b1;
            break;
         end
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL rst_mid_find got no read of pad 3 want one");
      end
      wb_rst_i = 1'b1;
      @(posedge wb_clk_i);
      #1;
      checks++;
      if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
           busy, done, err, err_code, err_idx} !== '0) begin
         errors++;
         $display("FAIL rst_mid_outputs got cyc=%b stb=%b adr=%h busy=%b want all 0",
                  wbm_cyc_o, wbm_stb_o, wbm_adr_o, busy);
      end
      @(negedge wb_clk_i);
      wb_rst_i = 1'b0;
      repeat (5) @(negedge wb_clk_i);
      checks++;
      if (wbm_cyc_o !== 1'b0 || busy !== 1'b0 || log_q.size() != 7) begin
         errors++;
         $display("FAIL rst_mid_quiet got cyc=%b busy=%b txns=%0d want 0 0 7",
                  wbm_cyc_o, busy, log_q.size());
      end
   endtask

   task automatic test_start_while_busy();
      logic [N-1:0] p;
      int dc, ec, wn;
      p = rand_profile();
      alt_profile = ~p;
      do_start(p, 1'b0, 1'b0);
      build_exp(p, 1'b0, -1, -1, -1);
      wait_end(20, dc, ec, wn);
      checks++;
      if (dc != 3 * N + 1) begin
         errors++;
         $display("FAIL busy_start_done got %0d want %0d", dc, 3 * N + 1);
      end
      checks++;
      if (log_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL busy_start_txn_count got %0d want %0d", log_q.size(), exp_q.size());
      end
      for (int i = 0; i < log_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (log_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL busy_start_txn[%0d] got %h want %h", i, log_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 6; k++) begin
         test_pass("random", rand_profile(), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)));
      end
   endtask

   initial begin
      test_reset();
      test_pass("plan_write", 38'h3F_C03F_FF80, 1'b0, 1'b0);
      test_pass("plan_verify", 38'h3F_C03F_FF80, 1'b1, 1'b0);
      test_mismatch();
      test_timeout(1'b0);
      test_timeout(1'b1);
      test_abort();
      test_reset_midpass();
      test_start_while_busy();
      test_pass("start_abort_same_cycle", rand_profile(), 1'b0, 1'b1);
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/pads_cfg_sequencer.md
Name: pads_cfg_sequencer

Overview:
- Wishbone master that programs all per-pad output-enable registers of the pad configuration slave from a 38-bit profile, in a single hardware-sequenced pass.
- Optionally reads each register back and checks it.
- Sits beside the management-core Wishbone path, at the slave window 0x3000_6000. It lets boot logic or a test mode switch the whole pad direction profile (e.g. RXD/TXD bank swap) without firmware loops.

Parameters:
- BASE_ADDR, 32'h3000_6000, base of the pad config window; pad i is at BASE_ADDR + i (byte address, bits[7:0] = i).
- NUM_PADS, 38, number of pad registers walked, 1..64.
- TIMEOUT, 16, maximum cycles to wait for ack per transaction, ≥ 2.

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  synchronous active-high reset.
- start  in  1  single-cycle request to run a programming pass.
- abort  in  1  cancels a running pass.
- verify_en  in  1  enables readback check; sampled with start.
- profile_oen  in  NUM_PADS  desired OEN per pad (1 = input, 0 = output); sampled with start.
- busy  out  1  pass in progress.
- done  out  1  one-cycle pulse on successful completion.
- err  out  1  sticky error flag, cleared by the next accepted start.
- err_code  out  2  00 none, 01 ack timeout, 10 readback mismatch, 11 aborted.
- err_idx  out  6  pad index at which the error occurred.
- wbm_cyc_o  out  1  Wishbone cycle.
- wbm_stb_o  out  1  Wishbone strobe.
- wbm_we_o  out  1  Wishbone write enable.
- wbm_sel_o  out  4  byte select.
- wbm_adr_o  out  32  Wishbone address.
- wbm_dat_o  out  32  Wishbone write data.
- wbm_dat_i  in  32  Wishbone read data.
- wbm_ack_i  in  1  Wishbone acknowledge.

Behaviour:
- Reset (synchronous, wb_rst_i = 1 at a clock edge):
  - All outputs go to 0. State goes to IDLE; idx = 0; timeout counter = 0.
  - Reset mid-transaction drops cyc/stb at that edge; no further bus activity.
- States: IDLE, WR_REQ, WR_GAP, RD_REQ, RD_GAP, DONE, ERR.
- IDLE / ERR:
  - start = 1 latches profile_oen and verify_en, clears err/err_code/err_idx, sets idx = 0, and moves to WR_REQ.
  - start is ignored while busy.
- WR_REQ:
  - Outputs: cyc = stb = we = 1, sel = 4'hF, adr = BASE_ADDR + idx, dat_o = {31'b0, profile[idx]}.
  - Outputs are held stable until ack is sampled.
  - On ack, go to WR_GAP and deassert cyc/stb at that edge.
- RD_REQ: same as WR_REQ with we = 0 and dat_o = 0. On ack, compare wbm_dat_i[0] with profile[idx] at that edge.
- *_GAP:
  - One mandatory idle cycle with cyc = stb = 0. wbm_ack_i is ignored here, because the slave returns one stale ack after stb drops.
  - WR_GAP goes to RD_REQ if verify is enabled, otherwise to the next pad.
  - RD_GAP goes to the next pad.
  - Next pad: idx + 1 → WR_REQ; after idx = NUM_PADS-1 → DONE.
- Latency:
  - With a 1-cycle ack slave, each transaction is 3 cycles (2 request + 1 gap).
  - Counting from the edge that samples start, done is high in cycle 3·NUM_PADS·(verify_en ? 2 : 1) + 1.
  - For 38 pads that is cycle 115 without verify, 229 with verify.
- DONE: done = 1 for exactly one cycle, busy = 0 in that cycle, then IDLE.
- busy = 1 in WR_REQ, WR_GAP, RD_REQ and RD_GAP only.
- Timeout:
  - The counter resets on entry to each *_REQ state and increments each cycle without ack.
  - When it reaches TIMEOUT-1 with no ack: go to ERR, err_code = 01, err_idx = idx, drop cyc/stb.
- Mismatch: go to ERR with code 10, err_idx = idx; remaining pads are not written.
- Abort:
  - When abort = 1 and busy, the next edge drops cyc/stb and goes to ERR with code 11, err_idx = current idx.
  - Abort has priority over a same-cycle ack and over timeout.
  - Abort in IDLE, DONE or ERR has no effect.
- Simultaneous start and abort in IDLE: start wins.
- ERR: err = 1 and is held until the next accepted start or reset; done is never pulsed after an error.
- Address arithmetic: idx is 6 bits, zero-extended and added to BASE_ADDR; no wrap past NUM_PADS-1.

Test Plan:
1. Reset, then start with profile_oen = 38'h3F_C03F_FF80 (hex form of the power-on OEN pattern), verify_en = 0, slave model 1-cycle ack → 38 writes to 0x3000_6000..0x3000_6025 with dat_o[0] matching each bit; done pulse in cycle 115; err = 0.
2. Same run with verify_en = 1 against a register model → alternating write/read per pad; done pulse in cycle 229; err_code = 00.
3. Verify run where the model forces bit 0 of pad 0x16 to read 1 when 0 was written → ERR, err_code = 10, err_idx = 22, no access to 0x3000_6017 afterwards.
4. Slave withholds ack for pad 5, TIMEOUT = 16 → cyc drops 16 cycles after the request begins; err_code = 01, err_idx = 5, busy = 0.
5. Assert abort during pad 10's WR_REQ in the same cycle as its ack → ERR with err_code = 11, err_idx = 10; then a new start clears err and completes the full pass.
6. Assert wb_rst_i during RD_REQ of pad 3 → next cycle all outputs are 0; start pulsed while busy is ignored (no restart, idx unchanged).
